icache_refill: RTL
==================

Name: icache_refill

Overview:
- Miss-handling stage directly downstream of the instruction cache's miss signal and upstream of its fill port.
- On a cache miss it fetches the missing 64-byte line from main memory as 16 word beats and assembles them into a 512-bit line.
- It drives the line on WM and pulses READY for one cycle so the cache installs it.
- It also provides the fetch-stage stall signal.

Parameters:
- WORDS_PER_LINE, 16, 32-bit words per cache line (fixed by the cache geometry).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- A  in  32  current fetch address (same value presented to the cache)
- cache_hit  in  1  hit indication from the cache
- mem_req  out  1  line read request to main memory; held until granted
- mem_addr  out  32  line-aligned byte address {A[31:6], 6'b0}
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  one data beat valid this cycle
- mem_rdata  in  32  data beat; beats arrive in order, word 0 first
- WM  out  512  assembled line; word k occupies WM[32k+31:32k]
- READY  out  1  one-cycle pulse: WM holds a complete line for the current A
- stall_f  out  1  fetch-stage stall = ~cache_hit

Behaviour:
- Reset (synchronous, active-high) sets the following. A reset in any state aborts the fill; beats already captured are discarded and READY is not raised.
  - state = IDLE
  - mem_req = 0, mem_addr = 0
  - WM = 0, READY = 0
  - beat counter = 0, latched block address = 0
- States: IDLE, REQ, FILL, DONE. Use a 2-bit encoding.
- IDLE:
  - If cache_hit = 0, latch blk = A[31:6] and set mem_addr = {A[31:6], 6'b0}.
  - Assert mem_req and go to REQ on the next edge.
- REQ:
  - mem_req = 1 until a cycle with mem_gnt = 1. mem_req then drops on the next edge, state goes to FILL, and beat = 0.
  - mem_rvalid is ignored in REQ.
- FILL:
  - On each cycle with mem_rvalid = 1, write mem_rdata into WM word[beat] and increment beat (4-bit).
  - When a valid beat arrives with beat = 15, go to DONE.
  - mem_rvalid = 0 cycles hold all state. There is no timeout.
- DONE: lasts exactly one cycle.
  - READY = 1 only if A[31:6] == blk. The cache writes on the following negedge and cache_hit rises.
  - If A changed during the fill (branch/jump redirect), READY stays 0 and the line is dropped.
  - Either way, the next state is IDLE. A new miss is evaluated in IDLE on the following cycle.
- READY is registered: asserted for exactly one cycle and never asserted outside DONE.
- WM is stable from DONE until the first beat of the next fill. Its contents are undefined to consumers while READY = 0.
- Minimum miss latency: 1 cycle (IDLE→REQ) + grant wait + 16 beats + 1 cycle (DONE). With a 20-cycle memory, READY rises 20+ cycles after the miss.
- If cache_hit goes to 1 during REQ/FILL (redirect to a resident line), the fill still completes. It is dropped at DONE unless the address matches.
- stall_f is purely combinational from cache_hit and is 0 whenever the cache hits.
- Only one outstanding request at a time. No prefetch.

Optional Feature:
- Macro ICACHE_REFILL_PERF_EN.
- When defined, add two outputs, both reset to 0 and saturating at 32'hFFFFFFFF:
  - miss_count[31:0]: increments on each IDLE→REQ transition.
  - drop_count[31:0]: increments on each DONE with an address mismatch.
- When undefined, these ports and counters do not exist, and the behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg holds:
  - WORDS_PER_LINE = 16, LINE_BITS = 512, OFFSET_BITS = 6, SET_BITS = 7, TAG_BITS = 19
  - State encoding constants: IDLE = 0, REQ = 1, FILL = 2, DONE = 3
  - The cache also uses this package.
- One natural sub-module: icache_line_buf, the 16×32 beat-assembly register with write-enable, 4-bit index and 512-bit flat output.

Test Plan:
- Basic miss: reset, A = 32'h0000_2040, cache_hit = 0, mem_gnt after 3 cycles, beats 32'hA000_0000+k for k = 0..15 → mem_addr = 32'h0000_2040, one READY pulse, WM[31:0] = A0000000, WM[511:480] = A000000F.
- Gapped beats: mem_rvalid toggling 1/0 for 32 cycles → READY exactly once, after the 16th valid beat. WM is correct.
- Redirect: miss at 32'h0000_1000, A changes to 32'h0000_3000 during beat 7 → no READY at DONE. A new request with mem_addr = 32'h0000_3000 is issued 2 cycles after DONE.
- Reset mid-fill: assert rst at beat 9 → next cycle state IDLE, mem_req = 0, READY = 0, WM = 0. No READY is ever produced for that fill.
- Stall path: toggle cache_hit 1/0/1 in IDLE → stall_f follows ~cache_hit in the same cycle, and mem_req rises the cycle after the 0.
- Perf (with ICACHE_REFILL_PERF_EN): 3 completed misses plus 1 redirect → miss_count = 4, drop_count = 1.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: line geometry, address split and refill FSM states.
package icache_pkg;

   localparam int unsigned WORDS_PER_LINE = 16;
   localparam int unsigned WORD_BITS      = 32;
   localparam int unsigned LINE_BITS      = WORDS_PER_LINE * WORD_BITS;
   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned OFFSET_BITS    = 6;
   localparam int unsigned SET_BITS       = 7;
   localparam int unsigned TAG_BITS       = ADDR_W - SET_BITS - OFFSET_BITS;
   localparam int unsigned BLK_BITS       = ADDR_W - OFFSET_BITS;
   localparam int unsigned BEAT_BITS      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } refill_state_e;

endpackage

// File: rtl/icache_line_buf.sv
// Beat-assembly register: 16 x 32-bit words written one at a time, exposed as a flat line.
module icache_line_buf
   import icache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [BEAT_BITS-1:0]  idx,
   input  logic [WORD_BITS-1:0]  wdata,
   output logic [LINE_BITS-1:0]  line
);

   logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0] words;

   // Capture one word per write; reset clears the whole line.
   always_ff @(posedge clk) begin
      if (rst) begin
         words <= '0;
      end else if (we) begin
         words[idx] <= wdata;
      end
   end

   assign line = words;

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: requests a line, assembles 16 beats, pulses READY when the
// line still matches the fetch address. Optional counters behind ICACHE_REFILL_PERF_EN.
module icache_refill
   import icache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     A,
   input  logic                  cache_hit,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [WORD_BITS-1:0]  mem_rdata,
   output logic [LINE_BITS-1:0]  WM,
   output logic                  READY,
   output logic                  stall_f
`ifdef ICACHE_REFILL_PERF_EN
   ,
   output logic [31:0]           miss_count,
   output logic [31:0]           drop_count
`endif
);

   refill_state_e          state;
   logic [BLK_BITS-1:0]    blk;
   logic [BEAT_BITS-1:0]   beat;
   logic [BLK_BITS-1:0]    a_blk;
   logic                   beat_we;
   logic                   last_beat;
   logic                   unused_offset;

   assign a_blk         = A[ADDR_W-1:OFFSET_BITS];
   assign unused_offset = ^A[OFFSET_BITS-1:0];
   assign beat_we       = (state == FILL) && mem_rvalid;
   assign last_beat     = beat_we && (beat == BEAT_BITS'(WORDS_PER_LINE - 1));
   assign stall_f       = ~cache_hit;

   icache_line_buf u_line_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (beat_we),
      .idx   (beat),
      .wdata (mem_rdata),
      .line  (WM)
   );

   // Refill FSM; READY is decided on the last beat so it is high for exactly the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         READY    <= 1'b0;
         beat     <= '0;
         blk      <= '0;
      end else begin
         READY <= 1'b0;
         case (state)
            IDLE: begin
               if (!cache_hit) begin
                  blk      <= a_blk;
                  mem_addr <= {a_blk, OFFSET_BITS'(0)};
                  mem_req  <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  beat    <= '0;
                  state   <= FILL;
               end
            end
            FILL: begin
               if (mem_rvalid) begin
                  beat <= beat + BEAT_BITS'(1);
               end
               if (last_beat) begin
                  READY <= (a_blk == blk);
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ICACHE_REFILL_PERF_EN
   // Saturating miss / dropped-line counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         miss_count <= '0;
         drop_count <= '0;
      end else begin
         if ((state == IDLE) && !cache_hit && (miss_count != '1)) begin
            miss_count <= miss_count + 32'd1;
         end
         if (last_beat && (a_blk != blk) && (drop_count != '1)) begin
            drop_count <= drop_count + 32'd1;
         end
      end
   end
`endif

endmodule
